// File: rtl/floppy_sensor_conditioner.sv
// Conditions raw floppy drive sensors into clean synchronous status flags:
// synchronize + debounce, index pulse shaping, revolution period, disk-change latch.
module floppy_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES    = 2000,
  parameter int INDEX_PULSE_CYCLES = 96000,
  parameter int PERIOD_W           = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ind_sens,
  input  logic                t00_sens,
  input  logic                wpr_sens,
  input  logic                dsk_sens,
  input  logic                chg_clr,
  output logic                index_active,
  output logic                track0_active,
  output logic                wprot_active,
  output logic                disk_present,
  output logic                disk_changed,
  output logic [PERIOD_W-1:0] rev_period,
  output logic                rev_valid
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int WW = (INDEX_PULSE_CYCLES > 1) ? $clog2(INDEX_PULSE_CYCLES + 1) : 1;
  // Channel order {dsk, wpr, t00, ind}; reset to inactive levels (index idles high).
  localparam logic [3:0] IDLE_LVL = 4'b0001;

  typedef enum logic {IDLE, PULSE} state_t;

  logic [3:0]         raw, sync1_q, sync2_q, db_q, db_d;
  logic [3:0][DW-1:0] cnt_q, cnt_d;
  logic               ind_dly_q;
  logic               hole_edge, dsk_fall;
  logic               disk_present_q, disk_present_d;
  logic               track0_q, track0_d, wprot_q, wprot_d;
  logic               disk_changed_q, disk_changed_d;
  state_t             state_q, state_d;
  logic [WW-1:0]      wcnt_q, wcnt_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d, rev_period_q, rev_period_d;
  logic               have_edge_q, have_edge_d, rev_valid_q, rev_valid_d;

  assign raw = {dsk_sens, wpr_sens, t00_sens, ind_sens};

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Status outputs take the debounced value one cycle later; a disk fall is
  // seen on the same edge that drops disk_present so dependents react in step.
  assign disk_present_d = db_q[3];
  assign track0_d       = db_q[1];
  assign wprot_d        = db_q[2] | ~db_q[3];
  assign dsk_fall       = disk_present_q & ~disk_present_d;
  assign hole_edge      = ind_dly_q & ~db_q[0] & disk_present_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: if (hole_edge) begin
        state_d = PULSE;
        wcnt_d  = WW'(INDEX_PULSE_CYCLES);
      end
      PULSE: if (wcnt_q <= WW'(1)) state_d = IDLE;
             else                  wcnt_d  = wcnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
    if (dsk_fall) state_d = IDLE;
  end

  always_comb begin
    per_cnt_d    = per_cnt_q;
    rev_period_d = rev_period_q;
    rev_valid_d  = 1'b0;
    have_edge_d  = have_edge_q;
    if (hole_edge) begin
      per_cnt_d   = PERIOD_W'(1);
      have_edge_d = 1'b1;
      if (have_edge_q && !(&per_cnt_q)) begin
        rev_period_d = per_cnt_q;
        rev_valid_d  = 1'b1;
      end
    end else if (!(&per_cnt_q)) begin
      per_cnt_d = per_cnt_q + 1'b1;
    end
    if (!disk_present_d) have_edge_d = 1'b0;
  end

  always_comb begin
    disk_changed_d = disk_changed_q;
    if (dsk_fall)     disk_changed_d = 1'b1;
    else if (chg_clr) disk_changed_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= IDLE_LVL;
      sync2_q        <= IDLE_LVL;
      db_q           <= IDLE_LVL;
      cnt_q          <= '0;
      ind_dly_q      <= 1'b1;
      disk_present_q <= 1'b0;
      track0_q       <= 1'b0;
      wprot_q        <= 1'b1;
      disk_changed_q <= 1'b1;
      state_q        <= IDLE;
      wcnt_q         <= '0;
      per_cnt_q      <= '0;
      rev_period_q   <= '0;
      rev_valid_q    <= 1'b0;
      have_edge_q    <= 1'b0;
    end else begin
      sync1_q        <= raw;
      sync2_q        <= sync1_q;
      db_q           <= db_d;
      cnt_q          <= cnt_d;
      ind_dly_q      <= db_q[0];
      disk_present_q <= disk_present_d;
      track0_q       <= track0_d;
      wprot_q        <= wprot_d;
      disk_changed_q <= disk_changed_d;
      state_q        <= state_d;
      wcnt_q         <= wcnt_d;
      per_cnt_q      <= per_cnt_d;
      rev_period_q   <= rev_period_d;
      rev_valid_q    <= rev_valid_d;
      have_edge_q    <= have_edge_d;
    end
  end

  assign index_active  = (state_q == PULSE);
  assign track0_active = track0_q;
  assign wprot_active  = wprot_q;
  assign disk_present  = disk_present_q;
  assign disk_changed  = disk_changed_q;
  assign rev_period    = rev_period_q;
  assign rev_valid     = rev_valid_q;
endmodule
